// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM ramp sequencer: states, register map and CTRL/STATUS bit positions.
// Purely declarative; no logic, so no latency or backpressure of its own.
package pwm_pkg;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PERIOD   = 3'd1;
  localparam logic [2:0] A_TARGET   = 3'd2;
  localparam logic [2:0] A_STEP     = 3'd3;
  localparam logic [2:0] A_INTERVAL = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;
  localparam logic [2:0] A_CURRENT  = 3'd6;

  localparam int C_START     = 0;
  localparam int C_STOP      = 1;
  localparam int C_IRQ_EN    = 2;
  localparam int C_IRQ_CLR   = 3;
  localparam int C_FAULT_CLR = 4;

  localparam int S_DONE   = 2;
  localparam int S_FAULT  = 3;
  localparam int S_IRQ_EN = 4;
endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational saturating step of cur toward tgt by step; never overshoots or wraps.
// Zero latency, no flow control.
module pwm_ramp_step
  import pwm_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] cur_i,
  input  logic [DW-1:0] tgt_i,
  input  logic [DW-1:0] step_i,
  output logic [DW-1:0] nxt_o
);
  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum   = {1'b0, cur_i} + {1'b0, step_i};
    diff  = {1'b0, cur_i} - {1'b0, step_i};
    nxt_o = cur_i;
    if (cur_i < tgt_i) begin
      nxt_o = (sum >= {1'b0, tgt_i}) ? tgt_i : sum[DW-1:0];
    end else if (cur_i > tgt_i) begin
      // diff[DW] is the borrow out: step larger than cur
      nxt_o = (diff[DW] || (diff[DW-1:0] <= tgt_i)) ? tgt_i : diff[DW-1:0];
    end
  end
endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Avalon-MM controller sequencing a PWM core: soft start/stop duty ramp, fault shutdown, done/fault irq.
// Reads return one cycle after avs_read with no wait states; duty/period change only on period_end, START or fault.
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int MIN_INTERVAL = 1
) (
  input  logic          csi_clk,
  input  logic          csi_reset,
  input  logic          avs_chipselect,
  input  logic [2:0]    avs_address,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic          avs_read,
  output logic [31:0]   avs_readdata,
  input  logic          coe_period_end,
  input  logic          coe_fault,
  output logic          coe_pwm_en,
  output logic [DW-1:0] coe_pwm_t,
  output logic [DW-1:0] coe_pwm_d,
  output logic          ins_irq
);
  localparam logic [31:0] MIN_IVL = 32'(MIN_INTERVAL);

  state_e        state_q, state_d;
  logic          en_q, en_d, stopping_q, stopping_d, done_q, done_d, fault_q, fault_d;
  logic          irq_en_q, irq_en_d, done_evt_q, done_evt_d, fault_evt_q, fault_evt_d;
  logic [DW-1:0] period_q, period_d, target_q, target_d, step_q, step_d;
  logic [DW-1:0] cur_q, cur_d, pwm_t_q, pwm_t_d;
  logic [31:0]   interval_q, interval_d, ivl_q, ivl_d, rdata_q, rdata_d;

  logic          wr, rd, ctrl_wr, start_c, stop_c, irq_clr_c, fault_clr_c;
  logic [DW-1:0] tgt_eff, step_nxt;
  logic [31:0]   ivl_load;

  assign wr          = avs_chipselect & avs_write;
  assign rd          = avs_chipselect & avs_read;
  assign ctrl_wr     = wr && (avs_address == A_CTRL);
  assign start_c     = ctrl_wr & avs_writedata[C_START];
  assign stop_c      = ctrl_wr & avs_writedata[C_STOP];
  assign irq_clr_c   = ctrl_wr & avs_writedata[C_IRQ_CLR];
  assign fault_clr_c = ctrl_wr & avs_writedata[C_FAULT_CLR];

  // Stopping overrides the programmed target with the soft-stop target of zero.
  assign tgt_eff  = stopping_q ? '0 : ((target_q < period_q) ? target_q : period_q);
  assign ivl_load = (interval_q < MIN_IVL) ? MIN_IVL : interval_q;

  pwm_ramp_step #(.DW(DW)) u_step (
    .cur_i  (cur_q),
    .tgt_i  (tgt_eff),
    .step_i (step_q),
    .nxt_o  (step_nxt)
  );

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    stopping_d  = stopping_q;
    done_d      = done_q;
    fault_d     = fault_q;
    irq_en_d    = irq_en_q;
    done_evt_d  = done_evt_q;
    fault_evt_d = fault_evt_q;
    period_d    = period_q;
    target_d    = target_q;
    step_d      = step_q;
    interval_d  = interval_q;
    ivl_d       = ivl_q;
    cur_d       = cur_q;
    pwm_t_d     = pwm_t_q;
    rdata_d     = rdata_q;

    if (wr) begin
      case (avs_address)
        A_PERIOD:   period_d   = DW'(avs_writedata);
        A_TARGET:   target_d   = DW'(avs_writedata);
        A_STEP:     step_d     = DW'(avs_writedata);
        A_INTERVAL: interval_d = avs_writedata;
        default: ;
      endcase
    end
    if (ctrl_wr) irq_en_d = avs_writedata[C_IRQ_EN];

    if (rd) begin
      rdata_d = '0;
      case (avs_address)
        A_PERIOD:   rdata_d = 32'(period_q);
        A_TARGET:   rdata_d = 32'(target_q);
        A_STEP:     rdata_d = 32'(step_q);
        A_INTERVAL: rdata_d = interval_q;
        A_STATUS: begin
          rdata_d[1:0]     = state_q;
          rdata_d[S_DONE]  = done_q;
          rdata_d[S_FAULT] = fault_q;
          rdata_d[S_IRQ_EN] = irq_en_q;
        end
        A_CURRENT:  rdata_d = 32'(cur_q);
        default: ;
      endcase
    end

    if (en_q && coe_period_end) pwm_t_d = period_q;

    if (coe_fault && (state_q != ST_IDLE)) begin
      state_d    = ST_FAULT;
      en_d       = 1'b0;
      cur_d      = '0;
      fault_d    = 1'b1;
      stopping_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c && !stop_c) begin
            state_d    = ST_RAMP;
            en_d       = 1'b1;
            cur_d      = '0;
            ivl_d      = ivl_load;
            done_d     = 1'b0;
            stopping_d = 1'b0;
            pwm_t_d    = period_q;
          end
        end
        ST_RAMP, ST_HOLD: begin
          if (stop_c) begin
            stopping_d = 1'b1;
            state_d    = ST_RAMP;
          end else if (state_q == ST_RAMP) begin
            if (coe_period_end) begin
              if (ivl_q <= 32'd1) begin
                cur_d = step_nxt;
                ivl_d = ivl_load;
                if (step_nxt == tgt_eff) begin
                  done_d = 1'b1;
                  if (stopping_q) begin
                    en_d       = 1'b0;
                    stopping_d = 1'b0;
                    state_d    = ST_IDLE;
                  end else begin
                    state_d = ST_HOLD;
                  end
                end
              end else begin
                ivl_d = ivl_q - 32'd1;
              end
            end
          end else if (tgt_eff != cur_q) begin
            done_d  = 1'b0;
            state_d = ST_RAMP;
          end
        end
        default: begin
          // Only reached with coe_fault low, so a clear here is always honoured.
          if (fault_clr_c) begin
            fault_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      endcase
    end

    if (irq_clr_c) begin
      done_evt_d  = 1'b0;
      fault_evt_d = 1'b0;
    end
    if (done_d && !done_q)   done_evt_d  = 1'b1;
    if (fault_d && !fault_q) fault_evt_d = 1'b1;
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      stopping_q  <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      done_evt_q  <= 1'b0;
      fault_evt_q <= 1'b0;
      period_q    <= '0;
      target_q    <= '0;
      step_q      <= '0;
      interval_q  <= '0;
      ivl_q       <= '0;
      cur_q       <= '0;
      pwm_t_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      stopping_q  <= stopping_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      irq_en_q    <= irq_en_d;
      done_evt_q  <= done_evt_d;
      fault_evt_q <= fault_evt_d;
      period_q    <= period_d;
      target_q    <= target_d;
      step_q      <= step_d;
      interval_q  <= interval_d;
      ivl_q       <= ivl_d;
      cur_q       <= cur_d;
      pwm_t_q     <= pwm_t_d;
      rdata_q     <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign coe_pwm_en   = en_q;
  assign coe_pwm_t    = pwm_t_q;
  assign coe_pwm_d    = cur_q;
  assign ins_irq      = irq_en_q & (done_evt_q | fault_evt_q);
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed scenarios plus randomized ramps against a step-sequence model.
module tb_pwm_ramp_sequencer;
  localparam int DW  = 32;
  localparam int GAP = 19;

  logic          csi_clk = 1'b0;
  logic          csi_reset = 1'b1;
  logic          avs_chipselect = 1'b0;
  logic [2:0]    avs_address = '0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_readdata;
  logic          coe_period_end = 1'b0;
  logic          coe_fault = 1'b0;
  logic          coe_pwm_en;
  logic [DW-1:0] coe_pwm_t;
  logic [DW-1:0] coe_pwm_d;
  logic          ins_irq;

  int     total = 0;
  int     bad = 0;
  bit     ien = 1'b0;
  longint exp_q[$];

  pwm_ramp_sequencer #(.DW(DW), .MIN_INTERVAL(1)) dut (
    .csi_clk        (csi_clk),
    .csi_reset      (csi_reset),
    .avs_chipselect (avs_chipselect),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .coe_period_end (coe_period_end),
    .coe_fault      (coe_fault),
    .coe_pwm_en     (coe_pwm_en),
    .coe_pwm_t      (coe_pwm_t),
    .coe_pwm_d      (coe_pwm_d),
    .ins_irq        (ins_irq)
  );

  always #5 csi_clk = ~csi_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference: list of duty values reached at each ramp step, ending when the target is hit.
  function automatic void mk_seq(input longint c, input longint t, input longint s);
    exp_q.delete();
    do begin
      if (t > c)      c = (c + s >= t) ? t : c + s;
      else if (t < c) c = (c - s <= t) ? t : c - s;
      exp_q.push_back(c);
    end while (c != t);
  endfunction

  function automatic logic [31:0] st(input int s, input bit done, input bit flt);
    return 32'(s) | (32'(done) << 2) | (32'(flt) << 3) | (32'(ien) << 4);
  endfunction

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge csi_clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge csi_clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge csi_clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(negedge csi_clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic ctrl(input logic [4:0] bits);
    bus_wr(3'd0, {27'd0, bits} | (ien ? 32'h4 : 32'h0));
  endtask

  task automatic pulse();
    @(negedge csi_clk); coe_period_end = 1'b1;
    @(negedge csi_clk); coe_period_end = 1'b0;
  endtask

  // Drives n period_end pulses per model step and checks duty after each pulse.
  task automatic run_steps(input int n, input longint start);
    longint prev, e;
    prev = start;
    foreach (exp_q[k]) begin
      for (int p = 1; p <= n; p++) begin
        pulse();
        e = (p == n) ? exp_q[k] : prev;
        total++;
        if (coe_pwm_d !== DW'(e)) begin
          bad++;
          $display("FAIL ramp_duty step=%0d pulse=%0d got=%0d exp=%0d", k, p, coe_pwm_d, e);
        end
        repeat (GAP) @(negedge csi_clk);
      end
      prev = exp_q[k];
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(posedge csi_clk);
    @(negedge csi_clk) csi_reset = 1'b0;
    total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0d exp=0", coe_pwm_en); end
    total++; if (coe_pwm_t !== '0) begin bad++; $display("FAIL reset_t got=%0d exp=0", coe_pwm_t); end
    total++; if (coe_pwm_d !== '0) begin bad++; $display("FAIL reset_d got=%0d exp=0", coe_pwm_d); end
    total++; if (ins_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0d exp=0", ins_irq); end
    total++; if (avs_readdata !== '0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", avs_readdata); end
    bus_rd(3'd5, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_status got=%0h exp=0", r); end
    bus_rd(3'd1, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", r); end
  endtask

  task automatic test_basic_ramp();
    logic [31:0] r;
    bus_wr(3'd1, 32'd1000); bus_wr(3'd2, 32'd300); bus_wr(3'd3, 32'd100); bus_wr(3'd4, 32'd2);
    ctrl(5'b00001);
    total++; if (coe_pwm_en !== 1'b1) begin bad++; $display("FAIL start_en got=%0d exp=1", coe_pwm_en); end
    total++; if (coe_pwm_d !== '0) begin bad++; $display("FAIL start_d got=%0d exp=0", coe_pwm_d); end
    total++; if (coe_pwm_t !== DW'(1000)) begin bad++; $display("FAIL start_t got=%0d exp=1000", coe_pwm_t); end
    bus_rd(3'd5, r);
    total++; if (r !== st(1, 0, 0)) begin bad++; $display("FAIL start_status got=%0h exp=%0h", r, st(1, 0, 0)); end
    mk_seq(0, 300, 100);
    run_steps(2, 0);
    bus_rd(3'd5, r);
    total++; if (r !== st(2, 1, 0)) begin bad++; $display("FAIL hold_status got=%0h exp=%0h", r, st(2, 1, 0)); end
    total++; if (ins_irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%0d exp=0", ins_irq); end
    ien = 1'b1; ctrl(5'b00000);
    total++; if (ins_irq !== 1'b1) begin bad++; $display("FAIL irq_done got=%0d exp=1", ins_irq); end
    ctrl(5'b01000);
    total++; if (ins_irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%0d exp=0", ins_irq); end
    bus_rd(3'd6, r);
    total++; if (r !== 32'd300) begin bad++; $display("FAIL current got=%0d exp=300", r); end
  endtask

  task automatic test_stop();
    logic [31:0] r;
    ctrl(5'b00010);
    mk_seq(300, 0, 100);
    run_steps(2, 300);
    total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL stop_en got=%0d exp=0", coe_pwm_en); end
    bus_rd(3'd5, r);
    total++; if (r !== st(0, 1, 0)) begin bad++; $display("FAIL stop_status got=%0h exp=%0h", r, st(0, 1, 0)); end
  endtask

  task automatic test_saturate();
    logic [31:0] r;
    bus_wr(3'd2, 32'd250);
    ctrl(5'b00001);
    mk_seq(0, 250, 100);
    run_steps(2, 0);
    bus_rd(3'd5, r);
    total++; if (r !== st(2, 1, 0)) begin bad++; $display("FAIL sat_status got=%0h exp=%0h", r, st(2, 1, 0)); end
    total++; if (ins_irq !== 1'b1) begin bad++; $display("FAIL sat_irq got=%0d exp=1", ins_irq); end
    ctrl(5'b01000);
    bus_wr(3'd2, 32'd2000);
    mk_seq(250, 1000, 100);
    run_steps(2, 250);
    bus_rd(3'd5, r);
    total++; if (r !== st(2, 1, 0)) begin bad++; $display("FAIL clamp_status got=%0h exp=%0h", r, st(2, 1, 0)); end
    total++; if (coe_pwm_t !== DW'(1000)) begin bad++; $display("FAIL clamp_t got=%0d exp=1000", coe_pwm_t); end
  endtask

  task automatic test_fault();
    logic [31:0] r;
    bus_wr(3'd3, 32'd400); bus_wr(3'd2, 32'd200);
    mk_seq(1000, 200, 400);
    run_steps(2, 1000);
    bus_wr(3'd2, 32'd500);
    pulse();
    total++; if (coe_pwm_d !== DW'(200)) begin bad++; $display("FAIL pre_fault_d got=%0d exp=200", coe_pwm_d); end
    @(negedge csi_clk) coe_fault = 1'b1;
    @(negedge csi_clk);
    total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL fault_en got=%0d exp=0", coe_pwm_en); end
    total++; if (coe_pwm_d !== '0) begin bad++; $display("FAIL fault_d got=%0d exp=0", coe_pwm_d); end
    bus_rd(3'd5, r);
    total++; if (r !== st(3, 0, 1)) begin bad++; $display("FAIL fault_status got=%0h exp=%0h", r, st(3, 0, 1)); end
    total++; if (ins_irq !== 1'b1) begin bad++; $display("FAIL fault_irq got=%0d exp=1", ins_irq); end
    ctrl(5'b10000);
    bus_rd(3'd5, r);
    total++; if (r !== st(3, 0, 1)) begin bad++; $display("FAIL fclr_held got=%0h exp=%0h", r, st(3, 0, 1)); end
    coe_fault = 1'b0;
    ctrl(5'b00001);
    total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL fault_start_en got=%0d exp=0", coe_pwm_en); end
    ctrl(5'b10000);
    bus_rd(3'd5, r);
    total++; if (r !== st(0, 0, 0)) begin bad++; $display("FAIL fclr_status got=%0h exp=%0h", r, st(0, 0, 0)); end
    ctrl(5'b01000);
    total++; if (ins_irq !== 1'b0) begin bad++; $display("FAIL fault_irq_clr got=%0d exp=0", ins_irq); end
  endtask

  task automatic test_start_stop();
    logic [31:0] r;
    ctrl(5'b00011);
    total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL ss_en got=%0d exp=0", coe_pwm_en); end
    bus_rd(3'd5, r);
    total++; if (r !== st(0, 0, 0)) begin bad++; $display("FAIL ss_status got=%0h exp=%0h", r, st(0, 0, 0)); end
  endtask

  task automatic test_interval0();
    logic [31:0] r;
    bus_wr(3'd4, 32'd0); bus_wr(3'd3, 32'd50); bus_wr(3'd2, 32'd100); bus_wr(3'd1, 32'd1000);
    ctrl(5'b00001);
    mk_seq(0, 100, 50);
    run_steps(1, 0);
    bus_rd(3'd5, r);
    total++; if (r !== st(2, 1, 0)) begin bad++; $display("FAIL ivl0_status got=%0h exp=%0h", r, st(2, 1, 0)); end
    ctrl(5'b00010);
    mk_seq(100, 0, 50);
    run_steps(1, 100);
    total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL ivl0_en got=%0d exp=0", coe_pwm_en); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    int p, t, teff, s, iv, n;
    for (int it = 0; it < 6; it++) begin
      p    = int'($urandom_range(1, 600));
      t    = int'($urandom_range(0, 800));
      teff = (t < p) ? t : p;
      s    = int'($urandom_range(1, 200));
      if (s < teff / 16 + 1) s = teff / 16 + 1;
      iv   = int'($urandom_range(0, 3));
      n    = (iv == 0) ? 1 : iv;
      bus_wr(3'd1, 32'(p)); bus_wr(3'd2, 32'(t)); bus_wr(3'd3, 32'(s)); bus_wr(3'd4, 32'(iv));
      ctrl(5'b00001);
      total++; if (coe_pwm_t !== DW'(p)) begin bad++; $display("FAIL rnd_t it=%0d got=%0d exp=%0d", it, coe_pwm_t, p); end
      mk_seq(0, teff, s);
      run_steps(n, 0);
      bus_rd(3'd5, r);
      total++; if (r !== st(2, 1, 0)) begin bad++; $display("FAIL rnd_hold it=%0d got=%0h exp=%0h", it, r, st(2, 1, 0)); end
      ctrl(5'b00010);
      mk_seq(teff, 0, s);
      run_steps(n, teff);
      total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL rnd_off it=%0d got=%0d exp=0", it, coe_pwm_en); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bus_wr(3'd4, 32'd1); bus_wr(3'd3, 32'd100); bus_wr(3'd2, 32'd300); bus_wr(3'd1, 32'd1000);
    ctrl(5'b00001);
    pulse();
    total++; if (coe_pwm_d !== DW'(100)) begin bad++; $display("FAIL mid_d got=%0d exp=100", coe_pwm_d); end
    @(negedge csi_clk) csi_reset = 1'b1;
    @(negedge csi_clk) csi_reset = 1'b0;
    ien = 1'b0;
    total++; if (coe_pwm_en !== 1'b0) begin bad++; $display("FAIL mrst_en got=%0d exp=0", coe_pwm_en); end
    total++; if (coe_pwm_d !== '0) begin bad++; $display("FAIL mrst_d got=%0d exp=0", coe_pwm_d); end
    total++; if (coe_pwm_t !== '0) begin bad++; $display("FAIL mrst_t got=%0d exp=0", coe_pwm_t); end
    bus_rd(3'd5, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL mrst_status got=%0h exp=0", r); end
    bus_rd(3'd2, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL mrst_target got=%0d exp=0", r); end
  endtask

  initial begin
    test_reset();
    test_basic_ramp();
    test_stop();
    test_saturate();
    test_fault();
    test_start_stop();
    test_interval0();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
